// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } muldiv_state_e;

    // Result override chosen when an op bypasses the iterative datapath
    typedef enum logic [1:0] {
        SP_NONE,
        SP_ONES,
        SP_A,
        SP_ZERO
    } muldiv_special_e;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand latches, shift-add / restoring-divide register and sign fixup for muldiv_sequencer.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            capture,
    input  logic            load,
    input  logic            step,
    input  logic            fixup,
    input  muldiv_special_e special,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output muldiv_op_e      op,
    output logic [XLEN-1:0] a_lat,
    output logic [XLEN-1:0] b_lat,
    output logic [XLEN-1:0] result
);

    muldiv_op_e        op_q;
    logic [XLEN-1:0]   a_q, b_q, mcand_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_step, prod_signed;
    logic              neg_q, sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b, rem_new, quo, rem, fix_val;
    logic [XLEN:0]     mul_sum, rem_ext, rem_diff;
    logic              rem_ge;

    always_comb begin
        sign_a = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sign_b = op_q inside {OP_MULH, OP_DIV, OP_REM};
        a_neg  = sign_a & a_q[XLEN-1];
        b_neg  = sign_b & b_q[XLEN-1];
        abs_a  = a_neg ? -a_q : a_q;
        abs_b  = b_neg ? -b_q : b_q;
    end

    // One iteration: multiply shifts right after a conditional add; divide shifts left
    // and keeps the bit that falls out of the remainder half so large divisors still compare.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        rem_ext  = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_ext - {1'b0, mcand_q};
        rem_ge   = rem_ext >= {1'b0, mcand_q};
        rem_new  = rem_ge ? rem_diff[XLEN-1:0] : rem_ext[XLEN-1:0];
        if (is_div(op_q)) begin
            acc_step = {rem_new, acc_q[XLEN-2:0], rem_ge};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_signed = neg_q ? -acc_q : acc_q;
        quo         = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem         = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                       fix_val = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = quo;
            default:                      fix_val = rem;
        endcase
        unique case (special)
            SP_ONES: fix_val = '1;
            SP_A:    fix_val = a_q;
            SP_ZERO: fix_val = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (capture) begin
                op_q <= muldiv_op_e'(funct3);
                a_q  <= a;
                b_q  <= b;
            end
            if (load) begin
                acc_q   <= {{XLEN{1'b0}}, abs_a};
                mcand_q <= abs_b;
                // Remainder follows the dividend; product and quotient follow both signs
                neg_q   <= (op_q inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
            end else if (step) begin
                acc_q <= acc_step;
            end
            if (fixup) begin
                result_q <= fix_val;
            end
        end
    end

    assign op     = op_q;
    assign a_lat  = a_q;
    assign b_lat  = b_q;
    assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: handshake, FSM, iteration counter and special-case decode.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    muldiv_state_e   state_q, state_d;
    muldiv_special_e special_q, special_d;
    muldiv_op_e      op;
    logic [XLEN-1:0] a_lat, b_lat;
    logic [5:0]      cnt_q;
    logic            ready_q, accept;

    assign accept = valid_i & ready_q & ~flush_i;

    always_comb begin
        special_d = SP_NONE;
        if (is_div(op)) begin
            if (b_lat == '0) begin
                special_d = (op inside {OP_DIV, OP_DIVU}) ? SP_ONES : SP_A;
            end else if ((op inside {OP_DIV, OP_REM}) &&
                         (a_lat == {1'b1, {(XLEN-1){1'b0}}}) && (b_lat == '1)) begin
                special_d = (op == OP_DIV) ? SP_A : SP_ZERO;
            end
        end
    end

    // Special cases still pass through FIXUP so every result is written by the same strobe
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_PREP;
            S_PREP:  state_d = (special_d != SP_NONE) ? S_FIXUP : S_CALC;
            S_CALC:  if (cnt_q == 6'(XLEN-1)) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            special_q <= SP_NONE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            if (state_q == S_PREP) special_q <= special_d;
            if (state_q == S_CALC && !flush_i) begin
                cnt_q <= cnt_q + 6'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .capture (accept),
        .load    ((state_q == S_PREP) && !flush_i),
        .step    ((state_q == S_CALC) && !flush_i),
        .fixup   ((state_q == S_FIXUP) && !flush_i),
        .special (special_q),
        .funct3  (funct3_i),
        .a       (a_i),
        .b       (b_i),
        .op      (op),
        .a_lat   (a_lat),
        .b_lat   (b_lat),
        .result  (result_o)
    );

    assign ready_o = ready_q;
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i, result_o;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics with 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return XLEN + 2;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic [31:0] first;
        bit          hold_bad;
        @(negedge clk_i);
        chk({tag, "/ready"}, 32'(ready_o), 32'd1);
        valid_i = 1'b1; funct3_i = f; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0; a_i = $urandom; b_i = $urandom; funct3_i = 3'($urandom);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(ref_latency(f, a, b)));
        chk({tag, "/result"}, result_o, ref_result(f, a, b));
        first = result_o;
        hold_bad = 1'b0;
        if (hold > 0) begin
            @(negedge clk_i);
            valid_i = 1'b1; funct3_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i); #1;
                if (result_o !== first || valid_o !== 1'b1 || ready_o !== 1'b0 || busy_o !== 1'b1)
                    hold_bad = 1'b1;
            end
            chk({tag, "/hold"}, 32'(hold_bad), 32'd0);
        end
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk({tag, "/drain"}, {29'd0, valid_o, busy_o, ready_o}, 32'd1);
        @(negedge clk_i);
        ready_i = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, "/noqueue"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          seen;
        rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; a_i = '0; b_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        chk("reset/ctrl", {29'd0, valid_o, busy_o, ready_o}, 32'd1);
        chk("reset/result", result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_op("mul_bp",      3'd0, 32'd7,         32'hFFFF_FFFD, 10);
        run_op("mulh",        3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu",      3'd2, 32'hFFFF_FFFF, 32'd2,         0);
        run_op("div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2,         0);
        run_op("rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2,         0);
        run_op("divu",        3'd5, 32'd100,       32'd7,         0);
        run_op("remu",        3'd7, 32'd100,       32'd7,         0);
        run_op("div_zero",    3'd4, 32'd5,         32'd0,         0);
        run_op("rem_zero",    3'd6, 32'h1234,      32'd0,         2);
        run_op("divu_zero",   3'd5, 32'hABCD_0000, 32'd0,         0);
        run_op("remu_zero",   3'd7, 32'hABCD_0001, 32'd0,         0);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
        end

        // Flush while the counter reads 15
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (16) @(posedge clk_i);
        #1 chk("flush/busy_before", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        chk("flush/idle", {29'd0, valid_o, busy_o, ready_o}, 32'd1);
        flush_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        chk("flush/no_valid", 32'(seen), 32'd0);

        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
        @(posedge clk_i); #1;
        chk("flush/no_accept", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b0;

        run_op("post_flush", 3'd0, 32'h0001_0003, 32'h0000_0101, 0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst/ctrl", {29'd0, valid_o, busy_o, ready_o}, 32'd1);
        chk("arst/result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op("post_reset", 3'd7, 32'hDEAD_BEEF, 32'd1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
